// File: rtl/fp_addsub_ctrl.sv
// Sequencer for IEEE-754 single-precision add/subtract around an external registered mantissa adder.
// Optional NaN/Inf handling in UNPACK is compiled in when FP_SPECIAL_EN is defined.
module fp_addsub_ctrl #(
  parameter int ADD_WAIT = 2,
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   opa,
  input  logic [EXP_W+MAN_W:0]   opb,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   ovf,
  output logic                   zero,
  output logic                   add_en,
  output logic [MAN_W:0]         add_a,
  output logic [MAN_W:0]         add_b,
  output logic                   add_sign_a,
  output logic                   add_sign_b,
  output logic                   add_op,
  output logic                   add_cin,
  input  logic [MAN_W:0]         add_sum,
  input  logic                   add_cout,
  input  logic                   add_ready
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MW    = MAN_W + 1;
  localparam int CNT_W = $clog2(ADD_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_WAIT - 1);
  localparam logic [EXP_W:0]   EXP_ONE  = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]   EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]   MW_E     = (EXP_W+1)'(MW);
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_opa, r_opb;
  logic             r_sub;
  logic             r_sign_l, r_eff_sub;
  logic [EXP_W:0]   r_exp, r_exp_s;
  logic [MAN_W:0]   r_man_l, r_man_s, r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_special;
  logic [W-1:0]     r_special_res;
  logic             r_busy, r_done, r_ovf, r_zero;
  logic [W-1:0]     r_result;
  logic             r_add_en, r_add_sign_b;
  logic [MAN_W:0]   r_add_a, r_add_b;

  logic [EXP_W-1:0] w_exp_a_raw, w_exp_b_raw;
  logic [EXP_W:0]   w_exp_a, w_exp_b, w_shift;
  logic [MAN_W:0]   w_man_a, w_man_b, w_man_s_al;
  logic             w_sign_b, w_a_ge_b;
  logic [EXP_W-1:0] w_pack_exp;

  // Subnormals carry no hidden bit and use an effective exponent of 1.
  assign w_exp_a_raw = r_opa[MAN_W +: EXP_W];
  assign w_exp_b_raw = r_opb[MAN_W +: EXP_W];
  assign w_exp_a     = (w_exp_a_raw == '0) ? EXP_ONE : {1'b0, w_exp_a_raw};
  assign w_exp_b     = (w_exp_b_raw == '0) ? EXP_ONE : {1'b0, w_exp_b_raw};
  assign w_man_a     = {(w_exp_a_raw != '0), r_opa[MAN_W-1:0]};
  assign w_man_b     = {(w_exp_b_raw != '0), r_opb[MAN_W-1:0]};
  assign w_sign_b    = r_opb[W-1] ^ r_sub;
  assign w_a_ge_b    = (r_opa[W-2:0] >= r_opb[W-2:0]);

  assign w_shift     = r_exp - r_exp_s;
  assign w_man_s_al  = (w_shift >= MW_E) ? '0 : (r_man_s >> w_shift);
  assign w_pack_exp  = r_sum[MAN_W] ? r_exp[EXP_W-1:0] : '0;

`ifdef FP_SPECIAL_EN
  logic         w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
  logic [W-1:0] w_special_res;

  assign w_a_inf   = (w_exp_a_raw == EXP_ALL1) && (r_opa[MAN_W-1:0] == '0);
  assign w_b_inf   = (w_exp_b_raw == EXP_ALL1) && (r_opb[MAN_W-1:0] == '0);
  assign w_a_nan   = (w_exp_a_raw == EXP_ALL1) && (r_opa[MAN_W-1:0] != '0);
  assign w_b_nan   = (w_exp_b_raw == EXP_ALL1) && (r_opb[MAN_W-1:0] != '0);
  assign w_special = w_a_inf | w_b_inf | w_a_nan | w_b_nan;

  always_comb begin
    w_special_res = {1'b0, EXP_ALL1, 1'b1, {(MAN_W-1){1'b0}}};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_opa[W-1] != w_sign_b)))
      w_special_res = {1'b0, EXP_ALL1, 1'b1, {(MAN_W-1){1'b0}}};
    else if (w_a_inf)
      w_special_res = {r_opa[W-1], EXP_ALL1, {MAN_W{1'b0}}};
    else
      w_special_res = {w_sign_b, EXP_ALL1, {MAN_W{1'b0}}};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_opa         <= '0;
      r_opb         <= '0;
      r_sub         <= 1'b0;
      r_sign_l      <= 1'b0;
      r_eff_sub     <= 1'b0;
      r_exp         <= '0;
      r_exp_s       <= '0;
      r_man_l       <= '0;
      r_man_s       <= '0;
      r_sum         <= '0;
      r_carry       <= 1'b0;
      r_cnt         <= '0;
      r_special     <= 1'b0;
      r_special_res <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_ovf         <= 1'b0;
      r_zero        <= 1'b0;
      r_add_en      <= 1'b0;
      r_add_a       <= '0;
      r_add_b       <= '0;
      r_add_sign_b  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa   <= opa;
            r_opb   <= opb;
            r_sub   <= op_sub;
            r_busy  <= 1'b1;
            r_state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          // Order by magnitude so the adder only ever computes |L| +/- |S|.
          if (w_a_ge_b) begin
            r_sign_l <= r_opa[W-1];
            r_exp    <= w_exp_a;
            r_man_l  <= w_man_a;
            r_exp_s  <= w_exp_b;
            r_man_s  <= w_man_b;
          end else begin
            r_sign_l <= w_sign_b;
            r_exp    <= w_exp_b;
            r_man_l  <= w_man_b;
            r_exp_s  <= w_exp_a;
            r_man_s  <= w_man_a;
          end
          r_eff_sub <= r_opa[W-1] ^ w_sign_b;
`ifdef FP_SPECIAL_EN
          r_special     <= w_special;
          r_special_res <= w_special_res;
          r_state       <= w_special ? S_PACK : S_ALIGN;
`else
          r_special     <= 1'b0;
          r_special_res <= '0;
          r_state       <= S_ALIGN;
`endif
        end
        S_ALIGN: begin
          r_add_a      <= r_man_l;
          r_add_b      <= w_man_s_al;
          r_add_sign_b <= r_eff_sub;
          r_add_en     <= 1'b1;
          r_cnt        <= '0;
          r_state      <= S_ADD;
        end
        S_ADD: begin
          if (add_ready) begin
            if (r_cnt == CNT_LAST) begin
              r_sum    <= add_sum;
              r_carry  <= add_cout;
              r_add_en <= 1'b0;
              r_state  <= S_NORM;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_NORM: begin
          if (r_carry) begin
            r_sum   <= {1'b1, r_sum[MAN_W:1]};
            r_exp   <= r_exp + EXP_ONE;
            r_carry <= 1'b0;
          end else if (r_sum == '0) begin
            r_state <= S_PACK;
          end else if (!r_sum[MAN_W] && (r_exp > EXP_ONE)) begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - EXP_ONE;
          end else begin
            r_state <= S_PACK;
          end
        end
        S_PACK: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_ovf   <= 1'b0;
          r_zero  <= 1'b0;
          r_state <= S_IDLE;
          if (r_special) begin
            r_result <= r_special_res;
          end else if (r_sum == '0) begin
            r_result <= '0;
            r_zero   <= 1'b1;
          end else if (r_exp >= EXP_MAX) begin
            r_result <= {r_sign_l, EXP_ALL1, {MAN_W{1'b0}}};
            r_ovf    <= 1'b1;
          end else begin
            r_result <= {r_sign_l, w_pack_exp, r_sum[MAN_W-1:0]};
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign ovf        = r_ovf;
  assign zero       = r_zero;
  assign add_en     = r_add_en;
  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign add_sign_a = 1'b0;
  assign add_sign_b = r_add_sign_b;
  assign add_op     = 1'b0;
  assign add_cin    = 1'b0;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Randomized bench for fp_addsub_ctrl with an arithmetic reference model and a registered adder stand-in.
module tb_fp_addsub_ctrl;

  logic        clk, rst, start, op_sub;
  logic [31:0] opa, opb, result;
  logic        busy, done, ovf, zero;
  logic        add_en, add_sign_a, add_sign_b, add_op, add_cin;
  logic [23:0] add_a, add_b, add_sum;
  logic        add_cout, add_ready;

  fp_addsub_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .zero(zero),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_sign_a(add_sign_a),
    .add_sign_b(add_sign_b), .add_op(add_op), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .add_ready(add_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered sign-magnitude mantissa adder: result and ready one cycle after en.
  always @(posedge clk) begin
    if (rst) begin
      add_ready <= 1'b0;
      add_sum   <= '0;
      add_cout  <= 1'b0;
    end else begin
      add_ready <= add_en;
      if (add_en) begin
        if (add_sign_a ^ add_sign_b ^ add_op)
          {add_cout, add_sum} <= {1'b0, add_a} - {1'b0, add_b};
        else
          {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + 25'(add_cin);
      end
    end
  end

  // Expected-value state written by the stimulus process
  int          launch_cnt = 0;
  int          s_cyc = 0, e_lat = 0, lit_lat = 0;
  logic [31:0] e_res = 0, lit_res = 0;
  logic        e_ovf = 0, e_zero = 0, e_eff = 0, has_lit = 0;
  logic [23:0] e_la = 0, e_sb = 0;

  // State owned by the compare process
  int          done_cnt = 0, n_checks = 0, n_pass = 0, rel = 0;
  logic [31:0] held_res = 0;
  logic        held_ovf = 0, held_zero = 0;

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] res, output logic o_ovf, output logic o_zero,
                                output int lat, output logic [23:0] la, output logic [23:0] sal,
                                output logic eff);
    logic [31:0] big, sml, ml, ms, sum;
    logic        sl, ss;
    int          el, es, d, e, lz, k, nsh;
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b; sl = a[31]; ss = b[31] ^ sub;
    end else begin
      big = b; sml = a; sl = b[31] ^ sub; ss = a[31];
    end
    el  = (big[30:23] == 8'h0) ? 1 : int'(big[30:23]);
    es  = (sml[30:23] == 8'h0) ? 1 : int'(sml[30:23]);
    ml  = {8'h0, (big[30:23] != 8'h0), big[22:0]};
    ms  = {8'h0, (sml[30:23] != 8'h0), sml[22:0]};
    d   = el - es;
    ms  = (d >= 24) ? 32'h0 : (ms >> d);
    la  = ml[23:0];
    sal = ms[23:0];
    eff = sl ^ ss;
    sum = eff ? (ml - ms) : (ml + ms);
    e   = el;
    nsh = 0;
    if (sum >= 32'h0100_0000) begin
      sum = sum >> 1; e = e + 1; nsh = 1;
    end
    o_ovf = 1'b0; o_zero = 1'b0;
    if (sum == 32'h0) begin
      res = 32'h0; o_zero = 1'b1;
    end else begin
      lz = 0;
      while (sum[23 - lz] == 1'b0) lz++;
      k   = (lz < e - 1) ? lz : e - 1;
      sum = sum << k;
      e   = e - k;
      nsh = nsh + k;
      if (e >= 255) begin
        res = {sl, 8'hFF, 23'h0}; o_ovf = 1'b1;
      end else begin
        res = {sl, (sum[23] ? 8'(e) : 8'h00), sum[22:0]};
      end
    end
    lat = 8 + nsh;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  // Single compare process: every cycle, #1 after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      done_cnt  = launch_cnt;
      held_res  = 32'h0;
      held_ovf  = 1'b0;
      held_zero = 1'b0;
    end
    if (launch_cnt != done_cnt) begin
      rel = cyc - s_cyc;
      chk("done", 32'(done), 32'(rel == e_lat));
      chk("busy", 32'(busy), 32'((rel >= 1) && (rel < e_lat)));
      chk("add_en", 32'(add_en), 32'((rel >= 3) && (rel <= 5)));
      if (add_en) begin
        chk("add_a", 32'(add_a), 32'(e_la));
        chk("add_b", 32'(add_b), 32'(e_sb));
        chk("add_sign_b", 32'(add_sign_b), 32'(e_eff));
        chk("add_ctl", {29'h0, add_sign_a, add_op, add_cin}, 32'h0);
      end
      if (rel == e_lat) begin
        chk("result", result, e_res);
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("zero", 32'(zero), 32'(e_zero));
        if (has_lit) begin
          chk("lit_result", result, lit_res);
          chk("model_pin", e_res, lit_res);
          chk("lit_latency", 32'(e_lat), 32'(lit_lat));
        end
        held_res  = e_res;
        held_ovf  = e_ovf;
        held_zero = e_zero;
        done_cnt  = launch_cnt;
      end else begin
        chk("result_hold", result, held_res);
        chk("ovf_hold", 32'(ovf), 32'(held_ovf));
        chk("zero_hold", 32'(zero), 32'(held_zero));
      end
    end else begin
      chk("idle_done", 32'(done), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_add_en", 32'(add_en), 32'h0);
      chk("idle_result", result, held_res);
      chk("idle_ovf", 32'(ovf), 32'(held_ovf));
      chk("idle_zero", 32'(zero), 32'(held_zero));
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic lit, input logic [31:0] lr, input int ll);
    logic [31:0] r;
    logic        o, z, ef;
    logic [23:0] la, sb;
    int          lat;
    @(negedge clk);
    model(a, b, sub, r, o, z, lat, la, sb, ef);
    e_res = r; e_ovf = o; e_zero = z; e_lat = lat; e_la = la; e_sb = sb; e_eff = ef;
    has_lit = lit; lit_res = lr; lit_lat = ll;
    s_cyc = cyc;
    opa = a; opb = b; op_sub = sub; start = 1'b1;
    launch_cnt++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && launch_cnt != done_cnt; i++) @(negedge clk);
    if (launch_cnt != done_cnt) begin
      $display("FAIL timeout: no completion for op started at cycle %0d", s_cyc);
      $fatal(1, "timeout");
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic lit, input logic [31:0] lr, input int ll, input logic dbl);
    launch(a, b, sub, lit, lr, ll);
    if (dbl) begin
      // A second start while busy must be ignored.
      @(negedge clk);
      opa = $urandom; opb = $urandom; op_sub = ~sub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
    $display("op %h %s %h -> %h (ovf=%0b zero=%0b, %0d cycles)",
             a, sub ? "-" : "+", b, result, ovf, zero, e_lat);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [22:0] f;
    case ($urandom_range(0, 4))
      0:       e = 8'h00;
      1:       e = 8'($urandom_range(253, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'h4000_0000, 9, 1'b0);
    run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h4000_0000, 8, 1'b0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b1, 1'b1, 32'hC000_0000, 8, 1'b0);
    run_op(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 1'b1, 32'h0000_0000, 8, 1'b0);
    run_op(32'hBF80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'h0000_0000, 8, 1'b0);
    run_op(32'h3F80_0000, 32'h3080_0000, 1'b0, 1'b1, 32'h3F80_0000, 8, 1'b0);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 1'b1, 32'h7F80_0000, 9, 1'b0);
    run_op(32'h3F80_0001, 32'h3F80_0000, 1'b1, 1'b1, 32'h3400_0000, 31, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0004, 8, 1'b0);
    run_op(32'h0080_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h007F_FFFF, 8, 1'b0);

    // Abort an operation in ADD with reset; no done may follow.
    launch(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h0, 0);
    for (int i = 0; i < 20 && !add_en; i++) @(negedge clk);
    if (!add_en) begin
      $display("FAIL reach_add: add_en never asserted");
      $fatal(1, "no ADD state");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    $display("op aborted by reset");

    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b1, 32'h4000_0000, 9, 1'b1);

    for (int n = 0; n < 300; n++) begin
      a = rnd_fp();
      b = rnd_fp();
      if ($urandom_range(0, 2) == 0) b[30:23] = a[30:23];
      run_op(a, b, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 0, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
